// File: rtl/conv_1x1_weight_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_1x1_weight_streamer_pkg
// Description : Shared conv_1x1 definitions: streamer FSM state encoding,
//               default geometry, the weight-count localparam N and the
//               helper that derives N from a given geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_1x1_weight_streamer_pkg;

    // Streamer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } wstream_state_e;

    // Default layer geometry
    localparam int C_DEF_CH_IN  = 256;
    localparam int C_DEF_CH_OUT = 512;
    localparam int C_DEF_KERNEL = 1;

    // Output skid buffer depth; also the limit on reads in flight plus buffered words
    localparam int C_SKID_DEPTH = 2;

    // Words in one full weight set: out-channel x in-channel x kernel x kernel
    function automatic int calc_n(input int ch_out, input int ch_in, input int kernel);
        return ch_out * ch_in * kernel * kernel;
    endfunction

    // N for the default geometry
    localparam int C_N_DEFAULT = C_DEF_CH_OUT * C_DEF_CH_IN * C_DEF_KERNEL * C_DEF_KERNEL;

endpackage
`default_nettype wire

// File: rtl/wstream_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : wstream_skid_buf
// Description : Two-entry skid buffer between the weight memory read port and
//               the conv weight port. Valid/ready on both sides. The output
//               word is taken straight from a storage register, so it stays
//               stable while the consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wstream_skid_buf
    import conv_1x1_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,        // asynchronous, active low
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [1:0]            o_count
);

    localparam logic [1:0] C_FULL = 2'(C_SKID_DEPTH);

    logic [DATA_WIDTH-1:0] r_entry0;
    logic [DATA_WIDTH-1:0] r_entry1;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_in_ready  = (r_count != C_FULL);
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_rd_ptr ? r_entry1 : r_entry0;
    assign o_count     = r_count;
    assign w_push      = i_in_valid & o_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;

    // Write the incoming word into the slot selected by the write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_wr_ptr <= 1'b0;
        end else if (w_push) begin
            if (r_wr_ptr) begin
                r_entry1 <= i_in_data;
            end else begin
                r_entry0 <= i_in_data;
            end
            r_wr_ptr <= ~r_wr_ptr;
        end
    end

    // Advance the read pointer on every accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
        end else if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_1x1_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module      : conv_1x1_weight_streamer
// Description : Streams one full 1x1-conv weight set (N words, address order
//               0..N-1) from a 1-cycle-latency weight memory to the conv
//               weight port over valid/ready. Reads are throttled so reads in
//               flight plus buffered words never exceed the 2-entry skid
//               buffer, which lets the stream run at one word per cycle with
//               ready_in high and lose nothing when ready_in drops.
//               Optional feature macro WSTREAM_REPEAT_EN: adds the repeat_num
//               input; the set is then sent repeat_num+1 times back to back.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_1x1_weight_streamer
    import conv_1x1_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 512,
    parameter int KERNEL          = 1,
    parameter int ADDR_WIDTH      = 17
) (
    input  logic                  clk,
    input  logic                  reset,            // asynchronous, active low
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   weight_cnt
`ifdef WSTREAM_REPEAT_EN
    ,
    input  logic [7:0]            repeat_num
`endif
);

    localparam int                  N           = calc_n(CHANNEL_NUM_OUT, CHANNEL_NUM_IN, KERNEL);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH:0]   C_LAST_CNT  = (ADDR_WIDTH + 1)'(N - 1);
    localparam logic [2:0]            C_LIMIT     = 3'(C_SKID_DEPTH);

    wstream_state_e        r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pend;          // read issued last cycle, data on mem_data now

    logic                  w_skid_in_ready;
    logic                  w_skid_valid;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic [1:0]            w_skid_count;
    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_room;
    logic                  w_rd_en;
    logic                  w_rd_wrap;
    logic                  w_acc_wrap;
    logic                  w_last_rd_pass;
    logic                  w_last_acc_pass;

    // A word leaving the buffer this cycle frees its slot for a read issued
    // this same cycle; that is what keeps the stream bubble-free.
    assign w_pop      = w_skid_valid & ready_in;
    assign w_push     = r_pend & w_skid_in_ready;
    assign w_occ      = {2'b00, r_pend} + {1'b0, w_skid_count};
    assign w_room     = (w_occ < (C_LIMIT + {2'b00, w_pop}));
    assign w_rd_en    = (r_state == ST_RUN) & w_room;
    assign w_rd_wrap  = w_rd_en & (r_addr == C_LAST_ADDR);
    assign w_acc_wrap = w_pop & (r_cnt == C_LAST_CNT);

`ifdef WSTREAM_REPEAT_EN
    logic [7:0] r_rep_num;
    logic [7:0] r_rd_pass;
    logic [7:0] r_acc_pass;

    assign w_last_rd_pass  = (r_rd_pass == r_rep_num);
    assign w_last_acc_pass = (r_acc_pass == r_rep_num);

    // Pass counters for the read side and the accept side, armed on start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rep_num  <= 8'd0;
            r_rd_pass  <= 8'd0;
            r_acc_pass <= 8'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_rep_num  <= repeat_num;
            r_rd_pass  <= 8'd0;
            r_acc_pass <= 8'd0;
        end else begin
            if (w_rd_wrap && !w_last_rd_pass) begin
                r_rd_pass <= r_rd_pass + 8'd1;
            end
            if (w_acc_wrap && !w_last_acc_pass) begin
                r_acc_pass <= r_acc_pass + 8'd1;
            end
        end
    end
`else
    assign w_last_rd_pass  = 1'b1;
    assign w_last_acc_pass = 1'b1;
`endif

    // Marks that a read was issued, so its data is pushed into the buffer next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_rd_en;
        end
    end

    // Control FSM: read address sequencing, accepted-word count, busy and done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    // The address points at the next read and never wraps
                    // past N-1 except into a further repeat pass.
                    if (w_rd_en) begin
                        if (w_rd_wrap) begin
                            if (w_last_rd_pass) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_addr <= '0;
                            end
                        end else begin
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                    end
                    // The final word can only be accepted in DRAIN, after all
                    // reads are out, so this cannot clash with the read branch.
                    if (w_pop) begin
                        if (w_acc_wrap) begin
                            if (w_last_acc_pass) begin
                                r_state <= ST_FIN;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_cnt   <= r_cnt + (ADDR_WIDTH + 1)'(1);
                            end else begin
                                r_cnt <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + (ADDR_WIDTH + 1)'(1);
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    wstream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (reset),
        .i_in_valid  (w_push),
        .o_in_ready  (w_skid_in_ready),
        .i_in_data   (mem_data),
        .o_out_valid (w_skid_valid),
        .i_out_ready (ready_in),
        .o_out_data  (w_skid_data),
        .o_count     (w_skid_count)
    );

    assign mem_rd_en        = w_rd_en;
    assign mem_addr         = r_addr;
    assign weight_out       = w_skid_data;
    assign valid_weight_out = w_skid_valid;
    assign busy             = r_busy;
    assign done             = r_done;
    assign weight_cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_conv_1x1_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_1x1_weight_streamer
// Description : Self-checking bench for conv_1x1_weight_streamer with a
//               4-in / 2-out / 1x1 geometry (N = 8) and a 1-cycle memory
//               holding address + 0x0100. A stream-level model is compared
//               with the DUT on every cycle; a few literal expectations pin
//               the model. Build with WSTREAM_REPEAT_EN to add repeat runs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_1x1_weight_streamer;

    localparam int DW   = 16;
    localparam int CIN  = 4;
    localparam int COUT = 2;
    localparam int KER  = 1;
    localparam int AW   = 17;
    localparam int N    = COUT * CIN * KER * KER;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] weight_out;
    logic          valid_weight_out;
    logic          ready_in;
    logic          busy;
    logic          done;
    logic [AW:0]   weight_cnt;
`ifdef WSTREAM_REPEAT_EN
    logic [7:0]    repeat_num;
`endif

    conv_1x1_weight_streamer #(
        .DATA_WIDTH      (DW),
        .CHANNEL_NUM_IN  (CIN),
        .CHANNEL_NUM_OUT (COUT),
        .KERNEL          (KER),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .weight_out       (weight_out),
        .valid_weight_out (valid_weight_out),
        .ready_in         (ready_in),
        .busy             (busy),
        .done             (done),
        .weight_cnt       (weight_cnt)
`ifdef WSTREAM_REPEAT_EN
        ,
        .repeat_num       (repeat_num)
`endif
    );

    always #5 clk = ~clk;

    // Weight memory: data returns one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= 16'h0100 + DW'(mem_addr);
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stream-level model state
    bit            m_active = 0;
    bit            m_done_due = 0;
    int            m_total = 0;
    int            m_acc = 0;
    int            m_reads = 0;
    int            m_start_edge = 0;
    bit            m_first_pending = 0;
    int            m_first_cyc = 0;
    logic [DW-1:0] m_first_data = '0;
    logic [DW-1:0] m_last_data = '0;
    int            m_done_cyc = 0;
    int            m_done_cnt = 0;
    bit            m_hold = 0;
    logic [DW-1:0] m_hold_data = '0;
    bit            m_prev_ctx = 0;
    bit            m_prev_rd = 0;
    logic [AW-1:0] m_prev_addr = '0;
    int            m_rep = 0;
    bit            chk_nobubble = 0;
    int            ready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of the DUT against the model, then model update
    task automatic mon();
        bit idle;
        bit pop;
        bit done_next;
        int exp_cnt;
        if (!reset) begin
            chk("rst_rd_en", mem_rd_en, 0);
            chk("rst_valid", valid_weight_out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_weight_out", weight_out, 0);
            chk("rst_weight_cnt", weight_cnt, 0);
            m_active = 0; m_done_due = 0; m_total = 0; m_acc = 0; m_reads = 0;
            m_first_pending = 0; m_hold = 0; m_prev_ctx = 0;
            return;
        end
        idle      = !m_active && !m_done_due;
        pop       = valid_weight_out && ready_in;
        done_next = 0;

        chk("done", done, m_done_due);
        if (done) begin m_done_cnt++; m_done_cyc = cyc; end
        chk("busy", busy, m_active);
        exp_cnt = (m_total != 0 && m_acc == m_total) ? N : (m_acc % N);
        chk("weight_cnt", weight_cnt, exp_cnt);

        if (m_hold) begin
            chk("stall_valid", valid_weight_out, 1);
            chk("stall_data", weight_out, m_hold_data);
        end
        if (valid_weight_out) begin
            if (m_active && m_acc < m_total) chk("weight_out", weight_out, 16'h0100 + (m_acc % N));
            else chk("valid_outside_stream", valid_weight_out, 0);
            if (m_first_pending) begin
                m_first_pending = 0;
                m_first_cyc     = cyc;
                m_first_data    = weight_out;
                chk("first_valid_latency", cyc - m_start_edge, 2);
            end
        end else if (m_active && !m_first_pending && chk_nobubble && m_acc < m_total) begin
            chk("no_bubble", valid_weight_out, 1);
        end

        if (m_prev_ctx && m_active && !m_prev_rd) chk("addr_hold", mem_addr, m_prev_addr);
        if (mem_rd_en) begin
            chk("rd_in_stream", m_active && (m_reads < m_total), 1);
            chk("rd_addr", mem_addr, m_reads % N);
            chk("rd_credit", (m_reads - m_acc - int'(pop)) < 2, 1);
            m_reads++;
        end
        m_prev_ctx  = m_active;
        m_prev_rd   = mem_rd_en;
        m_prev_addr = mem_addr;

        if (pop && m_active && m_acc < m_total) begin
            m_last_data = weight_out;
            m_acc++;
            if (m_acc == m_total) begin m_active = 0; done_next = 1; end
        end
        m_hold      = valid_weight_out && !ready_in;
        m_hold_data = weight_out;

        if (start && idle) begin
            m_active        = 1;
            m_start_edge    = cyc + 1;
            m_total         = N * (m_rep + 1);
            m_acc           = 0;
            m_reads         = 0;
            m_first_pending = 1;
        end
        m_done_due = done_next;
    endtask

    // One clock: check at the falling edge, drive ready_in just after the rising edge
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
        case (ready_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = ~ready_in;
            2:       ready_in = 1'($urandom_range(0, 1));
            default: ready_in = (m_first_pending || cyc < m_first_cyc + 10) ? 1'b0 : 1'b1;
        endcase
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (m_done_cnt == d0 && n < 400) begin tick(); n++; end
        chk("done_seen", m_done_cnt - d0, 1);
        repeat (3) tick();
    endtask

    task automatic run_stream(input int mode, input bit nb);
        int d0;
        ready_mode   = mode;
        chk_nobubble = nb;
        d0           = m_done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0);
    endtask

    initial begin
        int d0;
        reset = 1'b0; start = 1'b0; ready_in = 1'b0;
`ifdef WSTREAM_REPEAT_EN
        repeat_num = 8'd0;
`endif
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Full-rate stream with ready_in held high
        run_stream(0, 1);
        chk("s1_first_word", m_first_data, 16'h0100);
        chk("s1_last_word", m_last_data, 16'h0107);
        chk("s1_first_latency", m_first_cyc - m_start_edge, 2);
        chk("s1_done_cycle", m_done_cyc - m_start_edge, 10);
        chk("s1_final_cnt", weight_cnt, 8);
        chk("s1_final_addr", mem_addr, 7);

        // ready_in toggling every cycle
        run_stream(1, 0);
        chk("s2_last_word", m_last_data, 16'h0107);

        // ready_in low for 10 cycles after the first valid word
        ready_mode = 3; chk_nobubble = 0; d0 = m_done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        while (m_first_pending) tick();
        while (cyc < m_first_cyc + 9) tick();
        chk("s3_reads_while_stalled", m_reads, 2);
        chk("s3_head_word", weight_out, 16'h0100);
        wait_done(d0);

        // Reset after three transfers aborts the stream
        ready_mode = 0; chk_nobubble = 1; d0 = m_done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        while (m_acc < 3 && cyc < 1000) tick();
        reset = 1'b0;
        #1;
        chk("s4_async_valid", valid_weight_out, 0);
        chk("s4_async_busy", busy, 0);
        chk("s4_async_cnt", weight_cnt, 0);
        chk("s4_async_weight", weight_out, 0);
        chk("s4_async_addr", mem_addr, 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("s4_no_done", m_done_cnt - d0, 0);
        run_stream(0, 1);
        chk("s4_restart_word", m_first_data, 16'h0100);

        // start pulses while busy must be ignored
        ready_mode = 2; chk_nobubble = 0; d0 = m_done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(d0);
        chk("s5_words", m_acc, 8);

        // Random back-pressure
        for (int i = 0; i < 4; i++) run_stream(2, 0);

`ifdef WSTREAM_REPEAT_EN
        repeat_num = 8'd2; m_rep = 2;
        run_stream(0, 1);
        chk("r1_words", m_acc, 24);
        chk("r1_done_cycle", m_done_cyc - m_start_edge, 26);
        for (int i = 0; i < 3; i++) begin
            m_rep = int'($urandom_range(0, 3));
            repeat_num = 8'(m_rep);
            run_stream(2, 0);
        end
        repeat_num = 8'd0; m_rep = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
